// File: rtl/ram_rr_ctrl.sv
// rtl/ram_rr_ctrl.sv - two-requester round-robin controller for a 4x4-bit register RAM
module ram_rr_ctrl (
  input  logic       clk,
  input  logic       clear,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [1:0] addr_a,
  input  logic [1:0] addr_b,
  input  logic [3:0] wdata_a,
  input  logic [3:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [3:0] rdata,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0] state_q, state_d;
  logic       ptr_q, ptr_d;     // 0 = A has priority, 1 = B
  logic       win_q, win_d;     // 0 = A owns the transaction, 1 = B
  logic       we_q, we_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic [3:0] rdata_q, rdata_d;
  logic [3:0] mem_q [0:3];
  logic [3:0] mem_d [0:3];

  logic       pick_b;
  logic [3:0] word_sel;
  logic [3:0] word_we;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pick_b  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = mem_q[i];
    end

    word_sel = 4'b0001 << addr_q;
    word_we  = word_sel & {4{we_q && (state_q == ST_ACCESS)}};

    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          // Pointer only breaks ties; a lone requester always wins.
          pick_b  = (req_a && req_b) ? ptr_q : req_b;
          win_d   = pick_b;
          we_d    = pick_b ? we_b    : we_a;
          addr_d  = pick_b ? addr_b  : addr_a;
          wdata_d = pick_b ? wdata_b : wdata_a;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_q[addr_q];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = ~win_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int i = 0; i < 4; i++) begin
      if (word_we[i]) begin
        mem_d[i] = wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 4'd0;
      rdata_q <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign gnt_a = busy & ~win_q;
  assign gnt_b = busy &  win_q;
  assign ack_a = (state_q == ST_DONE) & ~win_q;
  assign ack_b = (state_q == ST_DONE) &  win_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_rr_ctrl.sv
// tb/tb_ram_rr_ctrl.sv - directed scoreboard bench for ram_rr_ctrl
module tb_ram_rr_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       req_a, req_b, we_a, we_b;
  logic [1:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, ack_a, ack_b, busy;
  logic [3:0] rdata;

  ram_rr_ctrl dut (
    .clk(clk), .clear(clear),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
    .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       who;
    logic       rd;
    logic [3:0] data;
  } sb_t;

  sb_t        sbq[$];
  logic [3:0] mdl_mem [0:3];
  logic [3:0] rd_model;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_models();
    sbq.delete();
    rd_model = 4'd0;
    for (int i = 0; i < 4; i++) mdl_mem[i] = 4'd0;
  endtask

  // Scoreboard consumer and per-cycle invariants
  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      chk("gnt_exclusive", {31'd0, gnt_a & gnt_b}, 32'd0);
      chk("busy_vs_gnt", {31'd0, busy}, {31'd0, gnt_a | gnt_b});
      if (ack_a || ack_b) begin
        chk("ack_width", {31'd0, prev_ack}, 32'd0);
        chk("ack_exclusive", {31'd0, ack_a & ack_b}, 32'd0);
        chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("ack_who", {31'd0, ack_b}, {31'd0, e.who});
          if (e.rd) begin
            chk("rdata_read", {28'd0, rdata}, {28'd0, e.data});
            rd_model = e.data;
          end else begin
            chk("rdata_write_hold", {28'd0, rdata}, {28'd0, rd_model});
          end
        end
      end else begin
        chk("rdata_hold", {28'd0, rdata}, {28'd0, rd_model});
      end
      prev_ack = ack_a | ack_b;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic txn(input logic who, input logic we, input logic [1:0] addr, input logic [3:0] d);
    sb_t e;
    @(negedge clk);
    if (who) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = d;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = d;
    end
    e.who  = who;
    e.rd   = ~we;
    e.data = we ? 4'd0 : mdl_mem[addr];
    if (we) mdl_mem[addr] = d;
    sbq.push_back(e);
    @(negedge clk);
    chk("gnt_at_n1", {31'd0, who ? gnt_b : gnt_a}, 32'd1);
    // Withdraw and scramble: the transaction in flight must not notice.
    req_a = 1'b0; req_b = 1'b0;
    we_a = ~we; we_b = ~we; addr_a = ~addr; addr_b = ~addr; wdata_a = ~d; wdata_b = ~d;
    @(negedge clk);
    chk("ack_at_n2", {31'd0, who ? ack_b : ack_a}, 32'd1);
    @(negedge clk);
    chk("idle_at_n3", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {24'd0, gnt_a, gnt_b, ack_a, ack_b, busy, 3'd0}, 32'd0);
    chk(tag, {28'd0, rdata}, 32'd0);
  endtask

  initial begin
    int n;
    int t_ack [0:2];
    clear = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = 2'd0; addr_b = 2'd0; wdata_a = 4'd0; wdata_b = 4'd0;
    reset_models();

    // Reset with a request pending: nothing may start
    req_a = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_outputs");
    req_a = 1'b0;
    clear = 1'b1;
    mon_en = 1'b1;

    txn(1'b0, 1'b0, 2'd2, 4'h0);
    txn(1'b0, 1'b1, 2'd1, 4'h3);
    txn(1'b0, 1'b0, 2'd1, 4'h0);
    txn(1'b1, 1'b1, 2'd2, 4'hc);
    txn(1'b1, 1'b0, 2'd2, 4'h0);
    txn(1'b1, 1'b0, 2'd1, 4'h0);
    txn(1'b1, 1'b1, 2'd1, 4'h5);
    txn(1'b0, 1'b0, 2'd1, 4'h0);

    // Contention: both held from reset, A must go first then alternate
    @(negedge clk);
    mon_en = 1'b0;
    clear = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 4'h7;
    req_b = 1'b1; we_b = 1'b1; addr_b = 2'd3; wdata_b = 4'ha;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_with_reqs");
    reset_models();
    for (int k = 0; k < 4; k++) sbq.push_back('{who: k[0], rd: 1'b0, data: 4'h0});
    mdl_mem[0] = 4'h7;
    mdl_mem[3] = 4'ha;
    clear = 1'b1;
    mon_en = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (ack_a || ack_b) n++;
    end
    chk("contention_acks", n, 4);
    req_a = 1'b0; req_b = 1'b0;
    txn(1'b0, 1'b0, 2'd0, 4'h0);
    txn(1'b1, 1'b0, 2'd3, 4'h0);

    // Lone requester B held for three back-to-back reads
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b0; addr_b = 2'd3;
    for (int k = 0; k < 3; k++) sbq.push_back('{who: 1'b1, rd: 1'b1, data: mdl_mem[3]});
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      @(negedge clk);
      if (ack_b) begin
        t_ack[n] = cyc;
        n++;
      end
    end
    req_b = 1'b0;
    chk("single_req_acks", n, 3);
    if (n == 3) begin
      chk("single_req_period1", t_ack[1] - t_ack[0], 3);
      chk("single_req_period2", t_ack[2] - t_ack[1], 3);
    end
    @(negedge clk);
    @(negedge clk);
    chk("single_req_idle", {31'd0, busy}, 32'd0);

    // Reset landing on the ACCESS edge of a write
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 4'hf;
    @(negedge clk);
    chk("midreset_gnt", {31'd0, gnt_a}, 32'd1);
    mon_en = 1'b0;
    clear = 1'b0;
    req_a = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset_outputs");
    reset_models();
    clear = 1'b1;
    mon_en = 1'b1;
    txn(1'b0, 1'b0, 2'd2, 4'h0);
    txn(1'b1, 1'b0, 2'd3, 4'h0);
    txn(1'b0, 1'b1, 2'd3, 4'h9);
    txn(1'b1, 1'b0, 2'd3, 4'h0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
